// File: rtl/tcdm_bank_pkg.sv
// Shared types and constants for the TCDM bank responder.
// Optional feature macro used by the top: TCDM_BANK_RESP_PIPE_EN.
package tcdm_bank_pkg;

   localparam int TCDM_DATA_W = 32;
   localparam int TCDM_BE_W   = 4;
   localparam int TCDM_ADDR_W = 32;

   // One initiator port's request fields, bundled for muxing.
   typedef struct packed {
      logic [TCDM_ADDR_W-1:0] add;
      logic                   we;
      logic [TCDM_DATA_W-1:0] wdata;
      logic [TCDM_BE_W-1:0]   be;
   } tcdm_req_t;

   // One port's response, as held in a response register stage.
   typedef struct packed {
      logic [TCDM_DATA_W-1:0] rdata;
      logic                   valid;
   } tcdm_resp_t;

   // Merge new write data into an old word, byte by byte, under the enables.
   function automatic logic [TCDM_DATA_W-1:0] applyByteEnable(
      input logic [TCDM_DATA_W-1:0] oldWord,
      input logic [TCDM_DATA_W-1:0] newWord,
      input logic [TCDM_BE_W-1:0]   be
   );
      logic [TCDM_DATA_W-1:0] merged;
      merged = oldWord;
      for (int b = 0; b < TCDM_BE_W; b++) begin
         if (be[b]) begin
            merged[8*b +: 8] = newWord[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, scanning
// from a priority pointer that moves just past the last winner.
module tcdm_rr_arbiter #(
   parameter  int NB_PORTS = 4,
   localparam int PTR_W    = $clog2(NB_PORTS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NB_PORTS-1:0] i_req,
   output logic [NB_PORTS-1:0] o_gnt,
   output logic [PTR_W-1:0]    o_gntIdx,
   output logic                o_gntValid
);

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_cand;
   logic             w_found;

   // Scan ptr, ptr+1, ... (wrapping naturally, NB_PORTS is a power of two) and pick the first requester; nothing is granted while in reset.
   always_comb begin
      o_gnt      = '0;
      o_gntIdx   = '0;
      o_gntValid = 1'b0;
      w_cand     = '0;
      w_found    = 1'b0;
      if (!i_rst) begin
         for (int i = 0; i < NB_PORTS; i++) begin
            w_cand = r_ptr + PTR_W'(i);
            if (!w_found && i_req[w_cand]) begin
               w_found  = 1'b1;
               o_gntIdx = w_cand;
            end
         end
      end
      o_gntValid = w_found;
      if (w_found) begin
         o_gnt[o_gntIdx] = 1'b1;
      end
   end

   // Priority pointer moves to the port after the winner, and holds when idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= o_gntIdx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-ported 32-bit SRAM bank answering NB_PORTS TCDM initiators.
// Optional macro TCDM_BANK_RESP_PIPE_EN adds a second response stage
// (latency 2 instead of 1).
module tcdm_bank_responder
   import tcdm_bank_pkg::*;
#(
   parameter int NB_PORTS  = 4,
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_LSB  = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NB_PORTS-1:0]                   tcdm_req_i,
   input  logic [NB_PORTS-1:0][TCDM_ADDR_W-1:0]  tcdm_add_i,
   input  logic [NB_PORTS-1:0]                   tcdm_we_i,
   input  logic [NB_PORTS-1:0][TCDM_DATA_W-1:0]  tcdm_wdata_i,
   input  logic [NB_PORTS-1:0][TCDM_BE_W-1:0]    tcdm_be_i,
   output logic [NB_PORTS-1:0]                   tcdm_gnt_o,
   output logic [NB_PORTS-1:0][TCDM_DATA_W-1:0]  tcdm_r_rdata_o,
   output logic [NB_PORTS-1:0]                   tcdm_r_valid_o
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int PTR_W = $clog2(NB_PORTS);

   logic [TCDM_DATA_W-1:0] r_mem [MEM_DEPTH];

   tcdm_req_t              w_portReq [NB_PORTS];
   tcdm_req_t              w_selReq;
   logic [NB_PORTS-1:0]    w_gnt;
   logic [PTR_W-1:0]       w_gntIdx;
   logic                   w_gntValid;
   logic [IDX_W-1:0]       w_wordIdx;
   logic [TCDM_DATA_W-1:0] w_rdWord;
   logic                   w_unusedAddrBits;

   tcdm_resp_t             r_stage1 [NB_PORTS];
   tcdm_resp_t             w_outStage [NB_PORTS];

   tcdm_rr_arbiter #(
      .NB_PORTS (NB_PORTS)
   ) u_arbiter (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_req      (tcdm_req_i),
      .o_gnt      (w_gnt),
      .o_gntIdx   (w_gntIdx),
      .o_gntValid (w_gntValid)
   );

   assign tcdm_gnt_o = w_gnt;

   // Upper address bits and the byte offset are deliberately ignored, so out-of-range addresses alias onto the bank.
   assign w_unusedAddrBits = ^tcdm_add_i;

   // Bundle each port's request and select the winner's fields for the bank access.
   always_comb begin
      for (int k = 0; k < NB_PORTS; k++) begin
         w_portReq[k].add   = tcdm_add_i[k];
         w_portReq[k].we    = tcdm_we_i[k];
         w_portReq[k].wdata = tcdm_wdata_i[k];
         w_portReq[k].be    = tcdm_be_i[k];
      end
      w_selReq  = w_portReq[w_gntIdx];
      w_wordIdx = w_selReq.add[ADDR_LSB +: IDX_W];
      w_rdWord  = r_mem[w_wordIdx];
   end

   // Bank write under byte enables; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_gntValid && w_selReq.we) begin
         r_mem[w_wordIdx] <= applyByteEnable(r_mem[w_wordIdx], w_selReq.wdata, w_selReq.be);
      end
   end

   // First response stage: valid on the granted port, read data or zero for writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NB_PORTS; k++) begin
            r_stage1[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NB_PORTS; k++) begin
            r_stage1[k].valid <= w_gnt[k];
            r_stage1[k].rdata <= (w_gnt[k] && !w_selReq.we) ? w_rdWord : '0;
         end
      end
   end

`ifdef TCDM_BANK_RESP_PIPE_EN
   tcdm_resp_t r_stage2 [NB_PORTS];

   // Optional second response stage, cleared by reset like the first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NB_PORTS; k++) begin
            r_stage2[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NB_PORTS; k++) begin
            r_stage2[k] <= r_stage1[k];
         end
      end
   end

   // Responses leave from the second stage.
   always_comb begin
      for (int k = 0; k < NB_PORTS; k++) begin
         w_outStage[k] = r_stage2[k];
      end
   end
`else
   // Responses leave from the first stage.
   always_comb begin
      for (int k = 0; k < NB_PORTS; k++) begin
         w_outStage[k] = r_stage1[k];
      end
   end
`endif

   // Drive responses, suppressing any response while reset is held so in-flight traffic is dropped.
   always_comb begin
      for (int k = 0; k < NB_PORTS; k++) begin
         tcdm_r_valid_o[k] = w_outStage[k].valid & ~rst_i;
         tcdm_r_rdata_o[k] = rst_i ? '0 : w_outStage[k].rdata;
      end
   end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Self-checking bench for tcdm_bank_responder: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_tcdm_bank_responder;

`ifdef TCDM_BANK_RESP_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int NP    = 4;
   localparam int DEPTH = 1024;

   logic                clock;
   logic                rst;
   logic [NP-1:0]       req;
   logic [NP-1:0][31:0] add;
   logic [NP-1:0]       we;
   logic [NP-1:0][31:0] wdata;
   logic [NP-1:0][3:0]  be;
   logic [NP-1:0]       gnt;
   logic [NP-1:0][31:0] rdata;
   logic [NP-1:0]       rvalid;

   int totalChecks = 0;
   int badChecks   = 0;

   // pending requests, held until granted
   logic [NP-1:0] pend;
   logic [31:0]   pAdd   [NP];
   logic          pWe    [NP];
   logic [31:0]   pWdata [NP];
   logic [3:0]    pBe    [NP];
   bit            autoReissue;

   // reference model state
   logic [31:0] mMem   [DEPTH];
   bit          mKnown [DEPTH];
   int          mPtr;
   logic [NP-1:0] shValid [3];
   logic [31:0]   shData  [3][NP];
   bit            shCare  [3][NP];

   int          grantLog[$];
   logic [31:0] lastRd [NP];

   tcdm_bank_responder #(
      .NB_PORTS  (NP),
      .MEM_DEPTH (DEPTH),
      .ADDR_LSB  (2)
   ) dut (
      .clk_i          (clock),
      .rst_i          (rst),
      .tcdm_req_i     (req),
      .tcdm_add_i     (add),
      .tcdm_we_i      (we),
      .tcdm_wdata_i   (wdata),
      .tcdm_be_i      (be),
      .tcdm_gnt_o     (gnt),
      .tcdm_r_rdata_o (rdata),
      .tcdm_r_valid_o (rvalid)
   );

   // free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // count a comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // drive DUT inputs from the pending-request table
   task automatic applyStimulus(input bit rstNow);
      rst = rstNow;
      for (int k = 0; k < NP; k++) begin
         req[k]   = pend[k];
         add[k]   = pAdd[k];
         we[k]    = pWe[k];
         wdata[k] = pWdata[k];
         be[k]    = pBe[k];
      end
   endtask

   task automatic issue(input int k, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] b);
      pend[k]   = 1'b1;
      pAdd[k]   = a;
      pWe[k]    = w;
      pWdata[k] = d;
      pBe[k]    = b;
   endtask

   // one clock cycle: drive, check at negedge against the model, advance the model
   task automatic stepCycle(input bit rstNow);
      int win;
      int obsIdx;
      int w;
      logic [NP-1:0] expGnt;
      applyStimulus(rstNow);
      @(negedge clock);
      win    = -1;
      expGnt = '0;
      if (!rstNow) begin
         for (int i = 0; i < NP; i++) begin
            if (win < 0 && pend[(mPtr + i) % NP]) win = (mPtr + i) % NP;
         end
      end
      if (win >= 0) expGnt[win] = 1'b1;
      checkOutput("gnt", 32'(gnt), 32'(expGnt));
      obsIdx = -1;
      for (int k = 0; k < NP; k++) if (gnt[k]) obsIdx = k;
      if (obsIdx >= 0) grantLog.push_back(obsIdx);

      checkOutput("rvalid", 32'(rvalid), rstNow ? 32'h0 : 32'(shValid[0]));
      for (int k = 0; k < NP; k++) begin
         if (!rstNow && shValid[0][k]) begin
            if (shCare[0][k]) checkOutput("rdata", rdata[k], shData[0][k]);
            lastRd[k] = rdata[k];
         end else begin
            checkOutput("rdata_idle", rdata[k], 32'h0);
         end
      end

      // advance response schedule by one cycle
      for (int s = 0; s < 2; s++) begin
         shValid[s] = shValid[s+1];
         for (int k = 0; k < NP; k++) begin
            shData[s][k] = shData[s+1][k];
            shCare[s][k] = shCare[s+1][k];
         end
      end
      shValid[2] = '0;

      if (rstNow) begin
         for (int s = 0; s < 3; s++) shValid[s] = '0;
         mPtr = 0;
      end else if (win >= 0) begin
         w = int'((pAdd[win] >> 2) % DEPTH);
         shValid[LAT-1][win] = 1'b1;
         if (pWe[win]) begin
            shData[LAT-1][win] = 32'h0;
            shCare[LAT-1][win] = 1'b1;
            for (int b = 0; b < 4; b++) begin
               if (pBe[win][b]) mMem[w][8*b +: 8] = pWdata[win][8*b +: 8];
            end
            if (pBe[win] == 4'hF) mKnown[w] = 1'b1;
         end else begin
            shData[LAT-1][win] = mMem[w];
            shCare[LAT-1][win] = mKnown[w];
         end
         mPtr = (win + 1) % NP;
         if (!autoReissue) pend[win] = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   // step until every pending request is granted, then let responses drain
   task automatic drain();
      int n;
      n = 0;
      while (pend != '0 && n < 64) begin
         stepCycle(1'b0);
         n++;
      end
      if (pend != '0) begin
         checkOutput("drain_timeout", 32'(pend), 32'h0);
         pend = '0;
      end
      repeat (LAT + 1) stepCycle(1'b0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] r;
      pend        = '0;
      autoReissue = 1'b0;
      mPtr        = 0;
      for (int k = 0; k < NP; k++) begin
         pAdd[k] = '0; pWe[k] = 1'b0; pWdata[k] = '0; pBe[k] = '0; lastRd[k] = '0;
      end
      for (int s = 0; s < 3; s++) begin
         shValid[s] = '0;
         for (int k = 0; k < NP; k++) begin
            shData[s][k] = '0; shCare[s][k] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         mMem[i] = '0; mKnown[i] = 1'b0;
      end
      applyStimulus(1'b1);
      @(posedge clock);
      #1;

      // reset state
      repeat (3) stepCycle(1'b1);

      // all ports reading continuously from reset: round-robin 0,1,2,3,0,1
      grantLog.delete();
      for (int k = 0; k < NP; k++) issue(k, 32'h100 + 32'(k * 4), 1'b0, 32'h0, 4'hF);
      autoReissue = 1'b1;
      repeat (6) stepCycle(1'b0);
      autoReissue = 1'b0;
      drain();
      for (int i = 0; i < 6; i++) checkOutput("rr_order", 32'(grantLog[i]), 32'(i % NP));

      // single port write then read
      issue(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
      drain();
      issue(0, 32'h10, 1'b0, 32'h0, 4'hF);
      drain();
      checkOutput("rd_deadbeef", lastRd[0], 32'hDEADBEEF);

      // partial byte enables
      issue(0, 32'h40, 1'b1, 32'h11223344, 4'hF);
      drain();
      issue(0, 32'h40, 1'b1, 32'hAABBCCDD, 4'b0101);
      drain();
      issue(0, 32'h40, 1'b0, 32'h0, 4'hF);
      drain();
      checkOutput("rd_be_merge", lastRd[0], 32'h11BB33DD);

      // empty byte enable still responds and leaves the word alone
      issue(1, 32'h40, 1'b1, 32'hFFFFFFFF, 4'h0);
      drain();
      issue(1, 32'h40, 1'b0, 32'h0, 4'hF);
      drain();
      checkOutput("rd_be_none", lastRd[1], 32'h11BB33DD);

      // address aliasing beyond the bank depth
      issue(0, 32'h0, 1'b1, 32'h5A5A5A5A, 4'hF);
      drain();
      issue(3, 32'h1000, 1'b0, 32'h0, 4'hF);
      drain();
      checkOutput("rd_alias", lastRd[3], 32'h5A5A5A5A);

      // write in n, read of the same word granted in n+1
      issue(1, 32'h20, 1'b1, 32'hCAFEF00D, 4'hF);
      stepCycle(1'b0);
      issue(2, 32'h20, 1'b0, 32'h0, 4'hF);
      drain();
      checkOutput("rd_hazard", lastRd[2], 32'hCAFEF00D);

      // reset the cycle after a read grant, with other requests waiting
      issue(0, 32'h10, 1'b0, 32'h0, 4'hF);
      stepCycle(1'b0);
      for (int k = 1; k < NP; k++) issue(k, 32'h200, 1'b0, 32'h0, 4'hF);
      stepCycle(1'b1);
      stepCycle(1'b1);
      issue(0, 32'h10, 1'b0, 32'h0, 4'hF);
      grantLog.delete();
      drain();
      checkOutput("ptr_after_reset", 32'(grantLog[0]), 32'h0);
      checkOutput("mem_retained", lastRd[0], 32'hDEADBEEF);

      // preload a small window of words, then randomized traffic on it
      for (int i = 0; i < 32; i++) begin
         issue(i % NP, 32'(i * 4), 1'b1, $urandom(), 4'hF);
         drain();
      end
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NP; k++) begin
            if (!pend[k] && $urandom_range(1, 0) == 1) begin
               a = $urandom();
               a[11:2] = 10'($urandom_range(31, 0));
               r = $urandom();
               issue(k, a, 1'($urandom_range(1, 0)), r, 4'($urandom_range(15, 0)));
            end
         end
         stepCycle(1'b0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Memory-side TCDM target that answers the TCDM request/grant/response protocol driven by the axi2mem TCDM master ports.
- Arbitrates NB_PORTS TCDM initiator ports onto one single-ported 32-bit SRAM bank with byte enables.
- Grants at most one request per cycle and returns the response on the granted port a fixed latency later.
- Used as the TCDM bank model/endpoint behind the axi2mem bridges in cluster and standalone subsystem builds.

Parameters:
- NB_PORTS, 4, number of TCDM initiator ports; power of two, 2..8.
- MEM_DEPTH, 1024, bank depth in 32-bit words; power of two.
- ADDR_LSB, 2, LSB of the word index within tcdm_add_i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- tcdm_req_i  in  NB_PORTS  per-port request.
- tcdm_add_i  in  NB_PORTSx32  byte address.
- tcdm_we_i  in  NB_PORTS  1 = write, 0 = read.
- tcdm_wdata_i  in  NB_PORTSx32  write data.
- tcdm_be_i  in  NB_PORTSx4  byte enables.
- tcdm_gnt_o  out  NB_PORTS  grant; combinational, same cycle as the request.
- tcdm_r_rdata_o  out  NB_PORTSx32  response data.
- tcdm_r_valid_o  out  NB_PORTS  response valid, one cycle per granted request.

Behaviour:
- Word index = tcdm_add_i[ADDR_LSB +: log2(MEM_DEPTH)]. Upper address bits and add[1:0] are ignored, so out-of-range addresses alias (wrap).
- Arbitration is round-robin with priority pointer ptr (log2 NB_PORTS bits).
  - Winner = first requesting port scanning ptr, ptr+1, ... mod NB_PORTS.
  - tcdm_gnt_o is one-hot or zero.
  - After a grant to port k, ptr <= (k+1) mod NB_PORTS. With no grant, ptr holds.
- Requests stay asserted until granted. A request on a losing port never receives gnt that cycle and keeps its add/we/wdata/be stable.
- Write on grant in cycle n: bytes with be[b]=1 update at the clock edge ending cycle n; bytes with be=0 are unchanged. be=4'b0000 is a no-op write but still gets a response.
- Read on grant in cycle n: tcdm_r_valid_o[k]=1 in cycle n+1 with r_rdata = word contents at the edge ending cycle n.
  - A write granted in cycle n is visible to a read granted in cycle n+1 (no hazard).
- Writes also respond: r_valid[k]=1 in cycle n+1 with r_rdata = 32'h0.
- Throughput is one access per cycle. Back-to-back grants to the same port give back-to-back r_valid.
- tcdm_r_rdata_o is driven only on the responding port. Non-responding ports hold 32'h0.
- Reset (rst_i=1 at an edge): ptr=0, all r_valid=0, all r_rdata=0.
  - While rst_i=1, tcdm_gnt_o is forced to 0 and no memory write occurs.
  - A response scheduled for the cycle after reset assertion is dropped.
  - Memory contents are not reset.
- Simultaneous requests on all ports with ptr=0 are served 0,1,2,3,0,... when every request is held.

Optional Feature:
- Macro TCDM_BANK_RESP_PIPE_EN.
- Defined: an extra response register stage is added, so read/write latency = 2 (r_valid in cycle n+2). Throughput stays one per cycle. Reset clears both stages. A write in n is still visible to a read granted in n+1.
- Undefined: latency = 1 as described above.

Decomposition:
- Package tcdm_bank_pkg:
  - TCDM_DATA_W=32, TCDM_BE_W=4.
  - typedef tcdm_req_t {add, we, wdata, be}.
  - typedef tcdm_resp_t {rdata, valid}.
- Sub-module tcdm_rr_arbiter (NB_PORTS): request vector in, one-hot grant out, pointer update on grant. The memory array and response routing stay in the top.

Test Plan:
- Single port 0: write add=0x10, wdata=0xDEADBEEF, be=4'hF, then read 0x10 -> gnt same cycle both times; write r_valid next cycle with rdata=0; read r_valid next cycle with rdata=0xDEADBEEF.
- Byte enables: word preset 0x11223344, write 0xAABBCCDD with be=4'b0101 -> later read returns 0x11BB33DD.
- All 4 ports request reads continuously from reset -> grants 0,1,2,3,0,1; each r_valid one cycle after its gnt; no two gnts in one cycle.
- Aliasing: write 0x5A5A5A5A at add=0x0 (MEM_DEPTH=1024), read add=0x1000 -> returns 0x5A5A5A5A.
- Write-then-read hazard: port 1 writes 0xCAFEF00D to 0x20 in cycle n, port 2 reads 0x20 granted in n+1 -> port 2 r_rdata=0xCAFEF00D; with TCDM_BANK_RESP_PIPE_EN, same data arrives one cycle later.
- Reset mid-traffic: assert rst_i the cycle after a read grant -> no r_valid, gnt=0 while in reset, ptr=0 after release; memory retains prior writes.
